// File: rtl/ask_pkg.sv
// Shared types, defaults and the keying level function for the ASK symbol keyer.
package ask_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ask_state_t;

    localparam int MPR  = 14;
    localparam int SPSW = 16;

    // Bit-0 level is an arithmetic attenuation; shifting by the full width or more
    // must give 0 rather than the sign fill, so that case is handled explicitly.
    function automatic logic signed [31:0] ask_level(input logic signed [31:0] sample,
                                                     input logic              bit_val,
                                                     input int                shift,
                                                     input int                width);
        if (bit_val)
            return sample;
        if (shift >= width)
            return '0;
        return sample >>> shift;
    endfunction

endpackage

// File: rtl/ask_bit_hold.sv
// One-entry data-bit holding register with accept, boundary take and bypass.
module ask_bit_hold (
    input  logic clk,
    input  logic reset,
    input  logic clken,
    input  logic din_bit,
    input  logic din_valid,
    input  logic take,
    input  logic bypass_en,
    output logic din_ready,
    output logic accept,
    output logic hold_full,
    output logic hold_bit
);

    assign din_ready = !hold_full;
    assign accept    = din_valid & din_ready & clken;

    // A bit bypassed straight into the current symbol never occupies the register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_bit  <= 1'b0;
        end else if (accept && !bypass_en) begin
            hold_full <= 1'b1;
            hold_bit  <= din_bit;
        end else if (take) begin
            hold_full <= 1'b0;
        end
    end

endmodule

// File: rtl/ask_sym_keyer.sv
// Binary ASK keyer: gates NCO carrier samples by a serial bit stream, one bit per sps samples.
module ask_sym_keyer
    import ask_pkg::*;
#(
    parameter int mpr     = MPR,
    parameter int spsw    = SPSW,
    parameter int loshift = 14
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clken,
    input  logic [spsw-1:0] sps,
    input  logic            din_bit,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic [mpr-1:0]  carrier_i,
    input  logic            carrier_vld,
    output logic [mpr-1:0]  ask_o,
    output logic            ask_valid,
    output logic            sym_strobe,
    output logic            underrun
);

    localparam logic [spsw-1:0] ONE = {{(spsw-1){1'b0}}, 1'b1};

    ask_state_t      state;
    logic [spsw-1:0] count;
    logic [spsw-1:0] sps_lat;
    logic            cur_bit;

    logic            sample_ev;
    logic            at_end;
    logic            boundary;
    logic            bypass_en;
    logic            take;
    logic            accept;
    logic            hold_full;
    logic            hold_bit;
    logic            next_bit;
    logic            key_bit;
    logic [spsw-1:0] sps_eff;
    logic signed [31:0] level;

    assign sample_ev = clken & carrier_vld;
    assign at_end    = (count == (sps_lat - ONE));
    assign boundary  = sample_ev & (((state == IDLE) & hold_full) | ((state == RUN) & at_end));
    assign bypass_en = sample_ev & (state == RUN) & at_end & !hold_full;
    assign take      = boundary & hold_full;
    assign sps_eff   = (sps == '0) ? ONE : sps;
    assign next_bit  = hold_full ? hold_bit : (accept ? din_bit : 1'b0);
    assign key_bit   = boundary ? next_bit : cur_bit;
    assign level     = ask_level(32'($signed(carrier_i)), key_bit, loshift, mpr);

    ask_bit_hold u_hold (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .din_bit   (din_bit),
        .din_valid (din_valid),
        .take      (take),
        .bypass_en (bypass_en),
        .din_ready (din_ready),
        .accept    (accept),
        .hold_full (hold_full),
        .hold_bit  (hold_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            sps_lat    <= ONE;
            cur_bit    <= 1'b0;
            ask_o      <= '0;
            ask_valid  <= 1'b0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else if (clken) begin
            ask_valid  <= 1'b0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
            if (carrier_vld) begin
                case (state)
                    IDLE: begin
                        if (hold_full) begin
                            state      <= RUN;
                            cur_bit    <= hold_bit;
                            sps_lat    <= sps_eff;
                            count      <= '0;
                            ask_o      <= mpr'(level);
                            ask_valid  <= 1'b1;
                            sym_strobe <= 1'b1;
                        end
                    end
                    RUN: begin
                        ask_o     <= mpr'(level);
                        ask_valid <= 1'b1;
                        if (at_end) begin
                            // With no bit in hold or on the input a zero symbol is sent.
                            cur_bit    <= next_bit;
                            sps_lat    <= sps_eff;
                            count      <= '0;
                            sym_strobe <= 1'b1;
                            underrun   <= !hold_full & !accept;
                        end else begin
                            count <= count + ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ask_sym_keyer.sv
// Directed bench for ask_sym_keyer: a default OOK instance and a loshift=1 instance share the stimulus.
module tb_ask_sym_keyer;

    logic        clk = 1'b0;
    logic        reset;
    logic        clken;
    logic [15:0] sps;
    logic        din_bit;
    logic        din_valid;
    logic [13:0] carrier_i;
    logic        carrier_vld;

    logic        din_ready, ask_valid, sym_strobe, underrun;
    logic [13:0] ask_o;
    logic        din_ready_l1, ask_valid_l1, sym_strobe_l1, underrun_l1;
    logic [13:0] ask_o_l1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ask_sym_keyer dut (
        .clk(clk), .reset(reset), .clken(clken), .sps(sps),
        .din_bit(din_bit), .din_valid(din_valid), .din_ready(din_ready),
        .carrier_i(carrier_i), .carrier_vld(carrier_vld),
        .ask_o(ask_o), .ask_valid(ask_valid), .sym_strobe(sym_strobe), .underrun(underrun)
    );

    ask_sym_keyer #(.loshift(1)) dut_l1 (
        .clk(clk), .reset(reset), .clken(clken), .sps(sps),
        .din_bit(din_bit), .din_valid(din_valid), .din_ready(din_ready_l1),
        .carrier_i(carrier_i), .carrier_vld(carrier_vld),
        .ask_o(ask_o_l1), .ask_valid(ask_valid_l1), .sym_strobe(sym_strobe_l1), .underrun(underrun_l1)
    );

    task automatic cyc(input logic ce, input logic cv, input logic [13:0] car,
                       input logic dv, input logic db);
        clken       = ce;
        carrier_vld = cv;
        carrier_i   = car;
        din_valid   = dv;
        din_bit     = db;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        clken       = 1'b1;
        carrier_vld = 1'b0;
        carrier_i   = '0;
        din_valid   = 1'b0;
        din_bit     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ask_valid, sym_strobe, underrun, din_ready, ask_o} !== {4'b0001, 14'd0}) begin
            failures++;
            $display("FAIL reset_state got v=%b s=%b u=%b r=%b o=%0d want v=0 s=0 u=0 r=1 o=0",
                     ask_valid, sym_strobe, underrun, din_ready, ask_o);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 14'(50 + i), 1'b0, 1'b0);
            checks++;
            if ({ask_valid, din_ready, ask_o} !== {2'b01, 14'd0}) begin
                failures++;
                $display("FAIL idle_no_bit cyc=%0d got v=%b r=%b o=%0d want v=0 r=1 o=0",
                         i, ask_valid, din_ready, ask_o);
            end
        end
    endtask

    task automatic test_ramp();
        logic [13:0] exp_o;
        logic        exp_s;
        sps = 16'd4;
        do_reset();
        cyc(1'b1, 1'b0, 14'd0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b1, 14'(100 + i), (i == 1) || (i == 5), (i != 1));
            exp_o = (i >= 4 && i < 8) ? 14'd0 : 14'(100 + i);
            exp_s = (i % 4 == 0);
            checks++;
            if ({ask_valid, sym_strobe, underrun, ask_o} !== {1'b1, exp_s, 1'b0, exp_o}) begin
                failures++;
                $display("FAIL ramp_sps4 smp=%0d got v=%b s=%b u=%b o=%0d want v=1 s=%b u=0 o=%0d",
                         i, ask_valid, sym_strobe, underrun, ask_o, exp_s, exp_o);
            end
        end
    endtask

    task automatic test_underrun();
        logic [13:0] exp_o;
        logic        exp_s, exp_u;
        sps = 16'd3;
        do_reset();
        cyc(1'b1, 1'b0, 14'd0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b1, 14'(200 + i), 1'b0, 1'b0);
            exp_o = (i < 3) ? 14'(200 + i) : 14'd0;
            exp_s = (i % 3 == 0);
            exp_u = (i >= 3) && (i % 3 == 0);
            checks++;
            if ({ask_valid, sym_strobe, underrun, ask_o} !== {1'b1, exp_s, exp_u, exp_o}) begin
                failures++;
                $display("FAIL underrun_sps3 smp=%0d got v=%b s=%b u=%b o=%0d want v=1 s=%b u=%b o=%0d",
                         i, ask_valid, sym_strobe, underrun, ask_o, exp_s, exp_u, exp_o);
            end
        end
    endtask

    task automatic test_bypass();
        logic [13:0] exp_o;
        logic        exp_s, exp_u;
        sps = 16'd2;
        do_reset();
        cyc(1'b1, 1'b0, 14'd0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 14'(300 + i), (i == 2), 1'b1);
            exp_o = (i < 4) ? 14'(300 + i) : 14'd0;
            exp_s = (i % 2 == 0);
            exp_u = (i == 4);
            checks++;
            if ({ask_valid, sym_strobe, underrun, ask_o} !== {1'b1, exp_s, exp_u, exp_o}) begin
                failures++;
                $display("FAIL bypass smp=%0d got v=%b s=%b u=%b o=%0d want v=1 s=%b u=%b o=%0d",
                         i, ask_valid, sym_strobe, underrun, ask_o, exp_s, exp_u, exp_o);
            end
            if (i == 2) begin
                checks++;
                if (din_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL bypass_no_fill got din_ready=%b want 1", din_ready);
                end
            end
        end
    endtask

    task automatic test_clken_gaps();
        logic [13:0] exp_o;
        logic        exp_v, exp_s, ce, cv;
        int          n;
        sps = 16'd5;
        do_reset();
        cyc(1'b1, 1'b0, 14'd0, 1'b1, 1'b1);
        exp_o = '0;
        exp_v = 1'b0;
        exp_s = 1'b0;
        n     = 0;
        for (int i = 0; i < 45; i++) begin
            ce = (i % 3 != 2);
            cv = (i % 4 != 1);
            cyc(ce, cv, 14'(400 + n), 1'b1, 1'b0);
            if (ce) begin
                if (cv) begin
                    exp_v = 1'b1;
                    exp_o = (n < 5) ? 14'(400 + n) : 14'd0;
                    exp_s = (n % 5 == 0);
                    n++;
                end else begin
                    exp_v = 1'b0;
                    exp_s = 1'b0;
                end
            end
            checks++;
            if ({ask_valid, sym_strobe, underrun, ask_o} !== {exp_v, exp_s, 1'b0, exp_o}) begin
                failures++;
                $display("FAIL clken_gaps cyc=%0d got v=%b s=%b u=%b o=%0d want v=%b s=%b u=0 o=%0d",
                         i, ask_valid, sym_strobe, underrun, ask_o, exp_v, exp_s, exp_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        sps = 16'd4;
        do_reset();
        cyc(1'b1, 1'b0, 14'd0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 14'd500, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 14'd501, 1'b1, 1'b1);
        checks++;
        if (din_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_hold_full got din_ready=%b want 0", din_ready);
        end
        reset = 1'b1;
        cyc(1'b1, 1'b1, 14'd502, 1'b0, 1'b0);
        reset = 1'b0;
        checks++;
        if ({din_ready, ask_valid, sym_strobe, ask_o} !== {3'b100, 14'd0}) begin
            failures++;
            $display("FAIL mid_reset got r=%b v=%b s=%b o=%0d want r=1 v=0 s=0 o=0",
                     din_ready, ask_valid, sym_strobe, ask_o);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1, 14'(503 + i), 1'b0, 1'b0);
            checks++;
            if ({ask_valid, sym_strobe} !== 2'b00) begin
                failures++;
                $display("FAIL held_bit_dropped cyc=%0d got v=%b s=%b want v=0 s=0",
                         i, ask_valid, sym_strobe);
            end
        end
    endtask

    task automatic test_shift();
        sps = 16'd0;
        do_reset();
        cyc(1'b1, 1'b0, 14'd0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 14'h2001, 1'b0, 1'b0);
        checks++;
        if ({ask_valid_l1, sym_strobe_l1, underrun_l1, ask_o_l1, ask_o} !== {3'b110, 14'h3000, 14'd0}) begin
            failures++;
            $display("FAIL shift_neg got v=%b s=%b u=%b o_l1=%h o=%h want v=1 s=1 u=0 o_l1=3000 o=0000",
                     ask_valid_l1, sym_strobe_l1, underrun_l1, ask_o_l1, ask_o);
        end
        cyc(1'b1, 1'b1, 14'h1FFF, 1'b0, 1'b0);
        checks++;
        if ({din_ready_l1, sym_strobe_l1, underrun_l1, ask_o_l1} !== {3'b111, 14'h0FFF}) begin
            failures++;
            $display("FAIL shift_pos_sps0 got r=%b s=%b u=%b o_l1=%h want r=1 s=1 u=1 o_l1=0fff",
                     din_ready_l1, sym_strobe_l1, underrun_l1, ask_o_l1);
        end
    endtask

    initial begin
        reset       = 1'b0;
        clken       = 1'b0;
        sps         = 16'd4;
        din_bit     = 1'b0;
        din_valid   = 1'b0;
        carrier_i   = '0;
        carrier_vld = 1'b0;
        test_reset();
        test_ramp();
        test_underrun();
        test_bypass();
        test_clken_gaps();
        test_reset_mid();
        test_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
